// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops TX FIFO bytes and serializes them as 8N1 (8E1 with UART_TX_PARITY_EN)
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       txd,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic txd_n;
  logic tick;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  assign tick = cnt == LAST;
  assign fifo_rdreq = (state == IDLE) & ~fifo_empty & ~reset;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = tick ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    txd_n = txd;
`ifdef UART_TX_PARITY_EN
    par_n = par;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        txd_n = 1'b1;
        state_n = fifo_rdreq ? FETCH : IDLE;
      end
      FETCH: begin
        shift_n = fifo_q;
        txd_n = 1'b0;
        cnt_n = '0;
        state_n = START;
`ifdef UART_TX_PARITY_EN
        par_n = ^fifo_q;
`endif
      end
      START: if (tick) begin
        txd_n = shift[0];
        idx_n = '0;
        state_n = DATA;
      end
      DATA: if (tick) begin
        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          txd_n = par;
          state_n = PARITY;
`else
          txd_n = 1'b1;
          state_n = STOP;
`endif
        end else begin
          shift_n = shift >> 1;
          txd_n = shift[1];
          idx_n = idx + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        txd_n = 1'b1;
        state_n = STOP;
      end
`endif
      STOP: state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      txd <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      txd <= txd_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule
